// File: rtl/varint_stream_encoder.sv
// varint_stream_encoder: buffers tagged words in a FIFO and serialises each one
// as a LEB128 uvarint, a zigzag svarint or strobed raw bytes, one byte per cycle.
module varint_stream_encoder #(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned IDX_W      = 10,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clock_clk,
    input  logic                          reset_reset,
    input  logic                          clr,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_data,
    input  logic [IDX_W-1:0]              in_index,
    input  logic [1:0]                    in_mode,
    input  logic [DATA_W/8-1:0]           in_strb,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [7:0]                    out_byte,
    output logic [IDX_W-1:0]              out_index,
    output logic                          out_last,
    output logic                          err_pulse,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH) + 1;

    localparam logic [1:0] MODE_UVAR   = 2'b00;
    localparam logic [1:0] MODE_ZIGZAG = 2'b01;
    localparam logic [1:0] MODE_RAW    = 2'b10;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [IDX_W-1:0]  index;
        logic [1:0]        mode;
        logic [STRB_W-1:0] strb;
    } entry_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_EMIT = 2'b10
    } state_e;

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    entry_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LVL_W-1:0]   level_n;
    logic               push_c;
    logic               pop_c;
    entry_t             head;
    entry_t             in_entry;

    assign push_c = in_valid && in_ready;
    assign head   = fifo_mem[rd_ptr];

    assign in_entry.data  = in_data;
    assign in_entry.index = in_index;
    assign in_entry.mode  = in_mode;
    assign in_entry.strb  = in_strb;

    // Next FIFO occupancy from this cycle's push/pop
    always_comb begin
        level_n = fifo_level;
        if (push_c && !pop_c) begin
            level_n = fifo_level + LVL_W'(1);
        end else if (!push_c && pop_c) begin
            level_n = fifo_level - LVL_W'(1);
        end
    end

    // FIFO pointers, level and registered ready
    always_ff @(posedge clock_clk or posedge reset_reset) begin
        if (reset_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            in_ready   <= 1'b1;
        end else if (clr) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            in_ready   <= 1'b1;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_level <= level_n;
            in_ready   <= (level_n != LVL_W'(FIFO_DEPTH));
        end
    end

    // FIFO storage, no reset needed since occupancy gates every read
    always_ff @(posedge clock_clk) begin
        if (push_c && !clr) begin
            fifo_mem[wr_ptr] <= in_entry;
        end
    end

    // ------------------------------------------------------------------
    // Encoder
    // ------------------------------------------------------------------
    state_e             state;
    state_e             state_n;
    logic [DATA_W-1:0]  sh_val;
    logic [DATA_W-1:0]  sh_val_n;
    logic [STRB_W-1:0]  sh_strb;
    logic [STRB_W-1:0]  sh_strb_n;
    logic               sh_raw;
    logic               sh_raw_n;
    logic               out_valid_n;
    logic [7:0]         out_byte_n;
    logic [IDX_W-1:0]   out_index_n;
    logic               out_last_n;
    logic               err_pulse_n;

    logic [DATA_W-1:0]  head_zz;
    logic [DATA_W-1:0]  src_val;
    logic [STRB_W-1:0]  src_strb;
    logic [7:0]         var_byte;
    logic               var_last;
    logic [DATA_W-1:0]  var_rem;
    logic [7:0]         raw_byte;
    logic [STRB_W-1:0]  raw_mask;
    logic [STRB_W-1:0]  raw_rem;
    logic               raw_last;

    assign head_zz = (head.data << 1) ^ {DATA_W{head.data[DATA_W-1]}};

    // Source for the next byte: FIFO head while loading, shift register after
    always_comb begin
        src_val  = sh_val;
        src_strb = sh_strb;
        if (state == ST_LOAD) begin
            src_val  = (head.mode == MODE_ZIGZAG) ? head_zz : head.data;
            src_strb = head.strb;
        end
    end

    // Next uvarint group: low 7 bits plus continuation flag
    always_comb begin
        var_rem  = src_val >> 7;
        var_last = (var_rem == '0);
        var_byte = {~var_last, src_val[6:0]};
    end

    // Lowest enabled raw lane and the strobes left after taking it
    always_comb begin
        raw_byte = '0;
        raw_mask = '0;
        for (int i = STRB_W - 1; i >= 0; i--) begin
            if (src_strb[i]) begin
                raw_byte = src_val[i*8 +: 8];
                raw_mask = '0;
                raw_mask[i] = 1'b1;
            end
        end
        raw_rem  = src_strb & ~raw_mask;
        raw_last = (raw_rem == '0);
    end

    // Next-state and output decode
    always_comb begin
        state_n     = state;
        pop_c       = 1'b0;
        sh_val_n    = sh_val;
        sh_strb_n   = sh_strb;
        sh_raw_n    = sh_raw;
        out_valid_n = out_valid;
        out_byte_n  = out_byte;
        out_index_n = out_index;
        out_last_n  = out_last;
        err_pulse_n = 1'b0;

        case (state)
            ST_IDLE: begin
                if (fifo_level != '0) begin
                    state_n = ST_LOAD;
                end
            end

            ST_LOAD: begin
                pop_c   = 1'b1;
                state_n = ST_IDLE;
                if (head.mode == MODE_UVAR || head.mode == MODE_ZIGZAG) begin
                    state_n     = ST_EMIT;
                    out_valid_n = 1'b1;
                    out_byte_n  = var_byte;
                    out_last_n  = var_last;
                    out_index_n = head.index;
                    sh_val_n    = var_rem;
                    sh_raw_n    = 1'b0;
                end else if (head.mode == MODE_RAW) begin
                    if (head.strb != '0) begin
                        state_n     = ST_EMIT;
                        out_valid_n = 1'b1;
                        out_byte_n  = raw_byte;
                        out_last_n  = raw_last;
                        out_index_n = head.index;
                        sh_val_n    = head.data;
                        sh_strb_n   = raw_rem;
                        sh_raw_n    = 1'b1;
                    end
                end else begin
                    err_pulse_n = 1'b1;
                end
            end

            ST_EMIT: begin
                if (out_ready) begin
                    if (out_last) begin
                        // Chain straight into the next entry to keep the gap to one cycle
                        out_valid_n = 1'b0;
                        out_last_n  = 1'b0;
                        state_n     = (fifo_level != '0) ? ST_LOAD : ST_IDLE;
                    end else if (sh_raw) begin
                        out_byte_n = raw_byte;
                        out_last_n = raw_last;
                        sh_strb_n  = raw_rem;
                    end else begin
                        out_byte_n = var_byte;
                        out_last_n = var_last;
                        sh_val_n   = var_rem;
                    end
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State, shift register and registered outputs
    always_ff @(posedge clock_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state     <= ST_IDLE;
            sh_val    <= '0;
            sh_strb   <= '0;
            sh_raw    <= 1'b0;
            out_valid <= 1'b0;
            out_byte  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            err_pulse <= 1'b0;
        end else if (clr) begin
            state     <= ST_IDLE;
            sh_val    <= '0;
            sh_strb   <= '0;
            sh_raw    <= 1'b0;
            out_valid <= 1'b0;
            out_byte  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            state     <= state_n;
            sh_val    <= sh_val_n;
            sh_strb   <= sh_strb_n;
            sh_raw    <= sh_raw_n;
            out_valid <= out_valid_n;
            out_byte  <= out_byte_n;
            out_index <= out_index_n;
            out_last  <= out_last_n;
            err_pulse <= err_pulse_n;
        end
    end

endmodule
